// File: rtl/axi4_slave_mem.sv
// AXI4 memory slave: independent write/read FSMs over a byte-strobed RAM, FIXED/INCR/WRAP bursts of 1..16 beats.
// Optional `define AXI_SLV_RANGE_CHK_EN: out-of-range words are suppressed and answered with SLVERR.
module axi4_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 9,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [3:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ID_WIDTH-1:0]     WID,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [3:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [1:0] B_FIXED = 2'b00, B_WRAP = 2'b10, B_RSVD = 2'b11;

  typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_RESP} wst_t;
  typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} rst_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
      input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, mask;
    step = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    if (burst == B_FIXED)
      next_addr = a;
    else if (burst == B_WRAP && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15))
      next_addr = (a & ~mask) | ((a + step) & mask);
    else
      next_addr = a + step;
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    word_idx = IW'((a >> LB) % ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  // ---------------- write channel ----------------
  wst_t                  w_state, w_nxt;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [3:0]            aw_len, w_cnt;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic                  w_err, w_fire, w_inrng, wid_unused;

  // ---------------- read channel -----------------
  rst_t                  r_state, r_nxt;
  logic [ADDR_WIDTH-1:0] ar_addr, rd_addr;
  logic [3:0]            ar_len, r_cnt;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst, rresp_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  r_berr, rd_berr, rlast_q, r_hs_ar, r_load, r_inrng;

`ifdef AXI_SLV_RANGE_CHK_EN
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    in_range = (a >> LB) < ADDR_WIDTH'(MEM_DEPTH);
  endfunction
  assign w_inrng = in_range(aw_addr);
  assign r_inrng = in_range(rd_addr);
`else
  assign w_inrng = 1'b1;
  assign r_inrng = 1'b1;
`endif

  assign wid_unused = ^WID;
  assign w_fire     = WVALID & WREADY;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) w_state <= W_INIT;
    else        w_state <= w_nxt;

  always_comb begin
    w_nxt = w_state;
    case (w_state)
      W_INIT:  w_nxt = W_IDLE;
      W_IDLE:  if (AWVALID) w_nxt = W_DATA;
      W_DATA:  if (WVALID && w_cnt == aw_len) w_nxt = W_RESP;
      W_RESP:  if (BREADY) w_nxt = W_IDLE;
      default: w_nxt = W_INIT;
    endcase
  end

  always_comb begin
    AWREADY = (w_state == W_IDLE);
    WREADY  = (w_state == W_DATA);
    BVALID  = (w_state == W_RESP);
    BID     = aw_id;
    BRESP   = {w_err, 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      aw_id <= '0; aw_addr <= '0; aw_len <= '0; aw_size <= '0; aw_burst <= '0;
      w_cnt <= '0; w_err <= 1'b0;
    end else if (AWVALID && AWREADY) begin
      aw_id <= AWID; aw_addr <= AWADDR; aw_len <= AWLEN; aw_size <= AWSIZE; aw_burst <= AWBURST;
      w_cnt <= '0;
      w_err <= (AWBURST == B_RSVD) || (AWSIZE > 3'(LB));
    end else if (w_fire) begin
      aw_addr <= next_addr(aw_addr, aw_len, aw_size, aw_burst);
      w_cnt   <= w_cnt + 4'd1;
      // burst length is fixed by AWLEN; WLAST only flags disagreement
      if ((WLAST != (w_cnt == aw_len)) || !w_inrng) w_err <= 1'b1;
    end

  always_ff @(posedge clk)
    if (w_fire && aw_size <= 3'(LB) && w_inrng)
      for (int i = 0; i < NB; i++)
        if (WSTRB[i]) mem[word_idx(aw_addr)][8*i +: 8] <= WDATA[8*i +: 8];

  assign r_hs_ar = ARVALID & ARREADY;
  assign r_load  = r_hs_ar | (RVALID & RREADY & ~rlast_q);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= R_INIT;
    else        r_state <= r_nxt;

  always_comb begin
    r_nxt = r_state;
    case (r_state)
      R_INIT:  r_nxt = R_IDLE;
      R_IDLE:  if (ARVALID) r_nxt = R_DATA;
      R_DATA:  if (RREADY && rlast_q) r_nxt = R_IDLE;
      default: r_nxt = R_INIT;
    endcase
  end

  always_comb begin
    ARREADY = (r_state == R_IDLE);
    RVALID  = (r_state == R_DATA);
    RID     = rid_q;
    RDATA   = rdata_q;
    RRESP   = rresp_q;
    RLAST   = rlast_q;
  end

  // Address of the beat to present next: the AR address when idle, else the successor of the current beat.
  always_comb begin
    if (r_state == R_DATA) begin
      rd_addr = next_addr(ar_addr, ar_len, ar_size, ar_burst);
      rd_berr = r_berr;
    end else begin
      rd_addr = ARADDR;
      rd_berr = (ARBURST == B_RSVD) || (ARSIZE > 3'(LB));
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ar_addr <= '0; ar_len <= '0; ar_size <= '0; ar_burst <= '0; r_berr <= 1'b0;
      r_cnt <= '0; rid_q <= '0; rdata_q <= '0; rresp_q <= '0; rlast_q <= 1'b0;
    end else begin
      if (r_hs_ar) begin
        ar_len <= ARLEN; ar_size <= ARSIZE; ar_burst <= ARBURST; rid_q <= ARID; r_berr <= rd_berr;
      end
      if (r_load) begin
        ar_addr <= rd_addr;
        r_cnt   <= r_hs_ar ? 4'd0 : r_cnt + 4'd1;
        rlast_q <= r_hs_ar ? (ARLEN == 4'd0) : (r_cnt + 4'd1 == ar_len);
        rresp_q <= {rd_berr | ~r_inrng, 1'b0};
        rdata_q <= r_inrng ? mem[word_idx(rd_addr)] : '0;
      end
    end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: bursts, wrap, strobes, back-pressure, errors, mid-burst reset.
module tb_axi4_slave_mem;
  localparam int DEPTH = 1024;
  localparam logic [1:0] BF = 2'b00, BI = 2'b01, BW = 2'b10, BR = 2'b11;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [8:0]  AWID = '0, WID = '0, BID, ARID = '0, RID;
  logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0, RDATA;
  logic [3:0]  AWLEN = '0, ARLEN = '0, WSTRB = '0;
  logic [2:0]  AWSIZE = '0, ARSIZE = '0;
  logic [1:0]  AWBURST = '0, ARBURST = '0, BRESP, RRESP;
  logic        AWVALID = 0, AWREADY, WLAST = 0, WVALID = 0, WREADY, BVALID, BREADY = 1;
  logic        ARVALID = 0, ARREADY, RLAST, RVALID, RREADY = 1;

  int checks = 0, errors = 0;
  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [8:0]  rd_id   [16];
  logic [1:0]  b_resp;
  logic [8:0]  b_id;
  bit w_prompt, b_prompt, b_stable, r_prompt, r_nogap, r_stable, r_end_ok;

  axi4_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(9), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY));

  always #5 clk = ~clk;

  task automatic do_write(input logic [8:0] id, input logic [31:0] addr, input logic [3:0] len,
      input logic [2:0] size, input logic [1:0] burst, input int early_last, input int bstall);
    int n;
    @(negedge clk);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1;
    BREADY = (bstall == 0);
    n = 0; while (!AWREADY && n < 50) begin @(negedge clk); n++; end
    checks++; if (!AWREADY) begin errors++; $display("FAIL aw_timeout got=0 exp=1"); AWVALID = 0; return; end
    @(negedge clk); AWVALID = 0;
    w_prompt = WREADY;
    for (int b = 0; b <= int'(len); b++) begin
      WID = id; WDATA = wr_data[b]; WSTRB = wr_strb[b]; WVALID = 1;
      WLAST = (early_last >= 0) ? (b == early_last) : (b == int'(len));
      n = 0; while (!WREADY && n < 50) begin @(negedge clk); n++; end
      checks++; if (!WREADY) begin errors++; $display("FAIL w_timeout beat=%0d", b); WVALID = 0; return; end
      @(negedge clk);
    end
    WVALID = 0; WLAST = 0;
    b_prompt = BVALID; b_resp = BRESP; b_id = BID; b_stable = 1;
    for (int k = 0; k < bstall; k++) begin
      @(negedge clk);
      if (!BVALID || BRESP !== b_resp || BID !== b_id) b_stable = 0;
    end
    BREADY = 1;
    n = 0; while (!BVALID && n < 50) begin @(negedge clk); n++; end
    checks++; if (!BVALID) begin errors++; $display("FAIL b_timeout got=0 exp=1"); return; end
    if (n > 0) begin b_resp = BRESP; b_id = BID; end
    @(negedge clk);
  endtask

  task automatic do_read(input logic [8:0] id, input logic [31:0] addr, input logic [3:0] len,
      input logic [2:0] size, input logic [1:0] burst, input int stall_beat, input int stall_n);
    int n;
    @(negedge clk);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1; RREADY = 1;
    n = 0; while (!ARREADY && n < 50) begin @(negedge clk); n++; end
    checks++; if (!ARREADY) begin errors++; $display("FAIL ar_timeout got=0 exp=1"); ARVALID = 0; return; end
    @(negedge clk); ARVALID = 0;
    r_prompt = RVALID; r_nogap = 1; r_stable = 1;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0; while (!RVALID && n < 50) begin @(negedge clk); n++; r_nogap = 0; end
      checks++; if (!RVALID) begin errors++; $display("FAIL r_timeout beat=%0d", b); return; end
      rd_data[b] = RDATA; rd_resp[b] = RRESP; rd_last[b] = RLAST; rd_id[b] = RID;
      if (b == stall_beat) begin
        RREADY = 0;
        repeat (stall_n) begin
          @(negedge clk);
          if (!RVALID || RDATA !== rd_data[b] || RRESP !== rd_resp[b] || RLAST !== rd_last[b] || RID !== rd_id[b])
            r_stable = 0;
        end
        RREADY = 1;
      end
      @(negedge clk);
    end
    r_end_ok = !RVALID && ARREADY;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA, RRESP, RLAST} !== '0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0", {AWREADY, WREADY, BVALID, ARREADY, RVALID});
    end
    rst_n = 1; #1;
    checks++; if (AWREADY !== 1'b0) begin errors++; $display("FAIL awready_before_edge got=%b exp=0", AWREADY); end
    @(negedge clk);
    checks++; if ({AWREADY, ARREADY} !== 2'b11) begin errors++; $display("FAIL ready_after_reset got=%b exp=11", {AWREADY, ARREADY}); end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
    do_write(9'h005, 32'h10, 4'd3, 3'd2, BI, -1, 0);
    checks++; if (!w_prompt) begin errors++; $display("FAIL incr_first_w got=0 exp=1"); end
    checks++; if (!b_prompt) begin errors++; $display("FAIL incr_b_latency got=0 exp=1"); end
    checks++; if ({b_resp, b_id} !== {2'b00, 9'h005}) begin errors++; $display("FAIL incr_bresp_bid got=%h/%h exp=0/005", b_resp, b_id); end
    do_read(9'h0A3, 32'h10, 4'd3, 3'd2, BI, -1, 0);
    checks++; if (!r_prompt) begin errors++; $display("FAIL incr_r_latency got=0 exp=1"); end
    checks++;
    if ({rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
      errors++; $display("FAIL incr_rdata got=%h %h %h %h exp=1 2 3 4", rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
    end
    checks++;
    if ({rd_last[0], rd_last[1], rd_last[2], rd_last[3]} !== 4'b0001) begin
      errors++; $display("FAIL incr_rlast got=%b%b%b%b exp=0001", rd_last[0], rd_last[1], rd_last[2], rd_last[3]);
    end
    checks++;
    if ({rd_resp[0], rd_resp[3], rd_id[0], rd_id[3], r_nogap, r_end_ok} !== {4'b0, 9'h0A3, 9'h0A3, 2'b11}) begin
      errors++; $display("FAIL incr_rresp_rid_flow got=%h/%h/%b/%b exp=0/0a3/1/1", rd_resp[0], rd_id[3], r_nogap, r_end_ok);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hA0 + 32'(i); wr_strb[i] = 4'hF; end
    do_write(9'h011, 32'h38, 4'd3, 3'd2, BW, -1, 0);
    checks++; if (b_resp !== 2'b00) begin errors++; $display("FAIL wrap_bresp got=%b exp=00", b_resp); end
    do_read(9'h012, 32'h30, 4'd3, 3'd2, BI, -1, 0);
    checks++;
    if ({rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !== {32'hA2, 32'hA3, 32'hA0, 32'hA1}) begin
      errors++; $display("FAIL wrap_layout got=%h %h %h %h exp=a2 a3 a0 a1", rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
    end
    do_read(9'h013, 32'h38, 4'd3, 3'd2, BW, -1, 0);
    checks++;
    if ({rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !== {32'hA0, 32'hA1, 32'hA2, 32'hA3}) begin
      errors++; $display("FAIL wrap_read got=%h %h %h %h exp=a0 a1 a2 a3", rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
    end
  endtask

  task automatic test_strobe_wlast();
    wr_data[0] = 32'h0; wr_strb[0] = 4'hF;
    do_write(9'h020, 32'h80, 4'd0, 3'd2, BI, -1, 0);
    wr_data[0] = 32'hFFFF_FFFF; wr_strb[0] = 4'b0101;
    do_write(9'h021, 32'h80, 4'd0, 3'd2, BI, -1, 0);
    do_read(9'h022, 32'h80, 4'd0, 3'd2, BI, -1, 0);
    checks++; if (rd_data[0] !== 32'h00FF_00FF) begin errors++; $display("FAIL strobe_lanes got=%h exp=00ff00ff", rd_data[0]); end
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hC0 + 32'(i); wr_strb[i] = 4'hF; end
    do_write(9'h023, 32'hC0, 4'd3, 3'd2, BI, 1, 0);
    checks++; if (b_resp !== 2'b10) begin errors++; $display("FAIL early_wlast_bresp got=%b exp=10", b_resp); end
  endtask

  task automatic test_back_pressure();
    do_read(9'h030, 32'h10, 4'd3, 3'd2, BI, 1, 3);
    checks++;
    if ({r_stable, rd_data[1], rd_data[2], rd_data[3]} !== {1'b1, 32'd2, 32'd3, 32'd4}) begin
      errors++; $display("FAIL rready_stall got=%b/%h/%h exp=1/2/4", r_stable, rd_data[1], rd_data[3]);
    end
    wr_data[0] = 32'h11; wr_data[1] = 32'h22; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    do_write(9'h031, 32'hD0, 4'd1, 3'd2, BI, -1, 2);
    checks++;
    if ({b_stable, b_resp, b_id} !== {1'b1, 2'b00, 9'h031}) begin
      errors++; $display("FAIL bready_stall got=%b/%b/%h exp=1/00/031", b_stable, b_resp, b_id);
    end
  endtask

  task automatic test_errors();
    wr_data[0] = 32'h5A; wr_data[1] = 32'h5B; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    do_write(9'h040, 32'hE0, 4'd1, 3'd2, BR, -1, 0);
    checks++; if (b_resp !== 2'b10) begin errors++; $display("FAIL rsvd_burst_bresp got=%b exp=10", b_resp); end
    do_read(9'h041, 32'hE0, 4'd1, 3'd2, BR, -1, 0);
    checks++;
    if ({rd_resp[0], rd_resp[1], rd_data[0], rd_data[1]} !== {4'b1010, 32'h5A, 32'h5B}) begin
      errors++; $display("FAIL rsvd_burst_read got=%b%b/%h/%h exp=1010/5a/5b", rd_resp[0], rd_resp[1], rd_data[0], rd_data[1]);
    end
    wr_data[0] = 32'h11; do_write(9'h042, 32'hF0, 4'd0, 3'd2, BI, -1, 0);
    wr_data[0] = 32'h99; do_write(9'h043, 32'hF0, 4'd0, 3'd3, BI, -1, 0);
    checks++; if (b_resp !== 2'b10) begin errors++; $display("FAIL oversize_bresp got=%b exp=10", b_resp); end
    do_read(9'h044, 32'hF0, 4'd0, 3'd2, BI, -1, 0);
    checks++; if (rd_data[0] !== 32'h11) begin errors++; $display("FAIL oversize_nowrite got=%h exp=11", rd_data[0]); end
    wr_data[0] = 32'h55; wr_data[1] = 32'h66;
    do_write(9'h045, 32'h100, 4'd1, 3'd2, BF, -1, 0);
    do_read(9'h046, 32'h100, 4'd1, 3'd2, BF, -1, 0);
    checks++;
    if ({rd_data[0], rd_data[1], rd_resp[1]} !== {32'h66, 32'h66, 2'b00}) begin
      errors++; $display("FAIL fixed_burst got=%h/%h/%b exp=66/66/00", rd_data[0], rd_data[1], rd_resp[1]);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    AWID = 9'h01F; AWADDR = 32'hA0; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = BI; AWVALID = 1;
    @(negedge clk); AWVALID = 0;
    WDATA = 32'h1; WSTRB = 4'hF; WLAST = 0; WVALID = 1;
    @(negedge clk); WDATA = 32'h2;
    @(negedge clk);
    rst_n = 0; #1;
    checks++;
    if ({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA, RRESP, RLAST} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs got=%b exp=0", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST});
    end
    WVALID = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'h71 + 32'(i); wr_strb[i] = 4'hF; end
    do_write(9'h050, 32'hA0, 4'd3, 3'd2, BI, -1, 0);
    checks++; if ({b_resp, b_id} !== {2'b00, 9'h050}) begin errors++; $display("FAIL post_reset_write got=%b/%h exp=00/050", b_resp, b_id); end
    do_read(9'h051, 32'hA0, 4'd3, 3'd2, BI, -1, 0);
    checks++;
    if ({rd_data[0], rd_data[3], rd_last[3]} !== {32'h71, 32'h74, 1'b1}) begin
      errors++; $display("FAIL post_reset_read got=%h/%h/%b exp=71/74/1", rd_data[0], rd_data[3], rd_last[3]);
    end
  endtask

  task automatic test_range();
    wr_data[0] = 32'h1234; wr_strb[0] = 4'hF;
    do_write(9'h060, 32'h0, 4'd0, 3'd2, BI, -1, 0);
`ifdef AXI_SLV_RANGE_CHK_EN
    do_read(9'h061, 32'(DEPTH * 4), 4'd0, 3'd2, BI, -1, 0);
    checks++; if ({rd_resp[0], rd_data[0]} !== {2'b10, 32'h0}) begin errors++; $display("FAIL range_read got=%b/%h exp=10/0", rd_resp[0], rd_data[0]); end
    wr_data[0] = 32'h5678;
    do_write(9'h062, 32'(DEPTH * 4), 4'd0, 3'd2, BI, -1, 0);
    checks++; if (b_resp !== 2'b10) begin errors++; $display("FAIL range_bresp got=%b exp=10", b_resp); end
    do_read(9'h063, 32'h0, 4'd0, 3'd2, BI, -1, 0);
    checks++; if (rd_data[0] !== 32'h1234) begin errors++; $display("FAIL range_nowrite got=%h exp=1234", rd_data[0]); end
`else
    do_read(9'h061, 32'(DEPTH * 4), 4'd0, 3'd2, BI, -1, 0);
    checks++; if ({rd_resp[0], rd_data[0]} !== {2'b00, 32'h1234}) begin errors++; $display("FAIL alias_read got=%b/%h exp=00/1234", rd_resp[0], rd_data[0]); end
    wr_data[0] = 32'h5678;
    do_write(9'h062, 32'(DEPTH * 4), 4'd0, 3'd2, BI, -1, 0);
    checks++; if (b_resp !== 2'b00) begin errors++; $display("FAIL alias_bresp got=%b exp=00", b_resp); end
    do_read(9'h063, 32'h0, 4'd0, 3'd2, BI, -1, 0);
    checks++; if (rd_data[0] !== 32'h5678) begin errors++; $display("FAIL alias_write got=%h exp=5678", rd_data[0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_strobe_wlast();
    test_back_pressure();
    test_errors();
    test_mid_reset();
    test_range();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
